// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge: asynchronous host parallel bus -> register file -> single-outstanding SoC transaction master.
// Define BRIDGE_TIMEOUT_EN to add a watchdog that abandons transactions stuck in WAIT.
module ext_bus_bridge #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          HOST_AW     = 25,
    parameter int          IDX_LSB     = 1,
    parameter int          SYNC_STAGES = 3,
    parameter logic [15:0] SANITY_VAL  = 16'h50FE,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_oe_o,
    input  logic [HOST_AW-1:0]    addr_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic                  cs_i,
    output logic                  cpu_rst_o,
    output logic                  soc_rst_o,
    output logic                  bus_master_o,
    output logic                  cpu_halt_o,
    output logic [31:0]           tran_addr_o,
    output logic [31:0]           tran_data_o,
    output logic [1:0]            tran_size_o,
    output logic                  tran_we_o,
    output logic                  tran_start_o,
    output logic                  tran_clear_o,
    input  logic [31:0]           tran_data_i,
    input  logic                  tran_ready_i
);
    localparam int LANES = 32 / DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} bridgeStateT;

    bridgeStateT            r_state;
    bridgeStateT            w_nextState;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [9:0]             r_ctrl;
    logic [31:0]            r_addr;
    logic [31:0]            r_dataIn;
    logic [31:0]            r_dataOut;
    logic [31:0]            r_tranAddr;
    logic [31:0]            r_tranData;
    logic [1:0]             r_tranSize;
    logic                   r_tranWe;
    logic                   r_done;
    logic                   r_clear;
    logic [DATA_WIDTH-1:0]  r_rdData;
    logic [DATA_WIDTH-1:0]  w_rdData;
    logic [3:0]             w_idx;
    logic [31:0]            w_incAddr;
    logic                   w_access;
    logic                   w_rdAcc;
    logic                   w_wrAcc;
    logic                   w_ctrlWr;
    logic                   w_startWr;
    logic                   w_clearWr;
    logic                   w_startAcc;
    logic                   w_complete;
    logic                   w_busy;
    logic                   w_expire;
    logic                   w_timeoutBit;
    logic                   w_unusedBits;

    // One access per cs assertion: rising edge seen between the two oldest synchroniser stages.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_csSync <= '0;
        else          r_csSync <= {r_csSync[SYNC_STAGES-2:0], cs_i};
    end

    assign w_access   = r_csSync[SYNC_STAGES-2] & ~r_csSync[SYNC_STAGES-1];
    assign w_rdAcc    = w_access & ~read_i;
    assign w_wrAcc    = w_access & ~write_i;
    assign w_idx      = addr_i[IDX_LSB+3:IDX_LSB];
    assign w_ctrlWr   = w_wrAcc && (w_idx == 4'd1);
    assign w_startWr  = w_ctrlWr & data_i[3];
    assign w_clearWr  = w_ctrlWr & data_i[5];
    assign w_startAcc = (r_state == IDLE) & w_startWr & ~w_clearWr;
    assign w_complete = (r_state == WAIT) & tran_ready_i;
    assign w_busy     = (r_state != IDLE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // A clear write overrides everything, including a completion in the same cycle.
    always_comb begin
        w_nextState = r_state;
        if (w_clearWr) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_startWr) w_nextState = REQ;
                REQ:     w_nextState = WAIT;
                WAIT:    if (tran_ready_i || w_expire) w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        w_incAddr = r_addr + 32'd4;
        case (r_tranSize)
            2'd0:    w_incAddr = r_addr + 32'd1;
            2'd1:    w_incAddr = r_addr + 32'd2;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ctrl     <= 10'h103;
            r_addr     <= '0;
            r_dataIn   <= '0;
            r_dataOut  <= '0;
            r_tranAddr <= '0;
            r_tranData <= '0;
            r_tranSize <= '0;
            r_tranWe   <= 1'b0;
            r_done     <= 1'b0;
            r_clear    <= 1'b0;
            r_rdData   <= '0;
        end else begin
            if (w_startAcc) begin
                r_tranAddr <= r_addr;
                r_tranData <= r_dataIn;
                r_tranSize <= data_i[7:6];
                r_tranWe   <= data_i[4];
            end
            if (w_complete) begin
                if (!r_tranWe)  r_dataOut <= tran_data_i;
                if (r_ctrl[9])  r_addr    <= w_incAddr;
            end
            // Host lane writes come after auto-increment so a same-cycle host write wins.
            if (w_wrAcc) begin
                if (w_idx == 4'd1) begin
                    if (DATA_WIDTH == 8) r_ctrl[7:0] <= 8'(data_i) & 8'hD7;
                    else                 r_ctrl      <= 10'(data_i) & 10'h3D7;
                end
                if ((DATA_WIDTH == 8) && (w_idx == 4'd3)) r_ctrl[9:8] <= data_i[1:0];
                for (int k = 0; k < LANES; k++) begin
                    if (w_idx == 4'(4 + k)) r_addr[k*DATA_WIDTH +: DATA_WIDTH]   <= data_i;
                    if (w_idx == 4'(8 + k)) r_dataIn[k*DATA_WIDTH +: DATA_WIDTH] <= data_i;
                end
            end
            if (w_rdAcc) r_rdData <= w_rdData;
            if (w_clearWr || w_startAcc) r_done <= 1'b0;
            else if (w_complete)         r_done <= 1'b1;
            r_clear <= w_clearWr | w_expire;
        end
    end

    always_comb begin
        w_rdData = '0;
        case (w_idx)
            4'd0:    w_rdData = DATA_WIDTH'(SANITY_VAL);
            4'd1:    w_rdData = DATA_WIDTH'(r_ctrl);
            4'd2:    w_rdData = DATA_WIDTH'({w_timeoutBit, r_done, w_busy});
            4'd3:    if (DATA_WIDTH == 8) w_rdData = DATA_WIDTH'(r_ctrl[9:8]);
            default: ;
        endcase
        for (int k = 0; k < LANES; k++) begin
            if (w_idx == 4'(4 + k))  w_rdData = r_addr[k*DATA_WIDTH +: DATA_WIDTH];
            if (w_idx == 4'(8 + k))  w_rdData = r_dataIn[k*DATA_WIDTH +: DATA_WIDTH];
            if (w_idx == 4'(12 + k)) w_rdData = r_dataOut[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdCnt;
    logic            r_timeout;

    // The counter's final value is the limit cycle; a ready there still completes normally.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wdCnt   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdCnt <= (r_state == WAIT) ? r_wdCnt + 1'b1 : '0;
            if (w_clearWr || w_startAcc) r_timeout <= 1'b0;
            else if (w_expire)           r_timeout <= 1'b1;
        end
    end

    assign w_expire     = (r_state == WAIT) && (r_wdCnt == WD_W'(TIMEOUT_CYC - 1)) && !tran_ready_i;
    assign w_timeoutBit = r_timeout;
    assign w_unusedBits = ^addr_i;
`else
    assign w_expire     = 1'b0;
    assign w_timeoutBit = 1'b0;
    assign w_unusedBits = ^{addr_i, (TIMEOUT_CYC == 0)};
`endif

    assign data_o       = r_rdData;
    assign data_oe_o    = ~read_i;
    assign cpu_rst_o    = r_ctrl[0];
    assign soc_rst_o    = r_ctrl[1];
    assign bus_master_o = r_ctrl[2];
    assign cpu_halt_o   = r_ctrl[8];
    assign tran_addr_o  = r_tranAddr;
    assign tran_data_o  = r_tranData;
    assign tran_size_o  = r_tranSize;
    assign tran_we_o    = r_tranWe;
    assign tran_start_o = (r_state == REQ);
    assign tran_clear_o = r_clear;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed self-checking bench for ext_bus_bridge (DATA_WIDTH=16, SYNC_STAGES=3, TIMEOUT_CYC=16).
// Host accesses are driven at the negative edge; a small responder model plays the SoC side.
module tb_ext_bus_bridge;
    localparam int SYNC = 3;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [15:0] data_o;
    logic        data_oe_o;
    logic [24:0] addr_i = '0;
    logic        read_i = 1'b1;
    logic        write_i = 1'b1;
    logic        cs_i = 1'b0;
    logic        cpu_rst_o, soc_rst_o, bus_master_o, cpu_halt_o;
    logic [31:0] tran_addr_o, tran_data_o;
    logic [1:0]  tran_size_o;
    logic        tran_we_o, tran_start_o, tran_clear_o;
    logic [31:0] tran_data_i = '0;
    logic        tran_ready_i = 1'b0;

    int          checkCount = 0;
    int          errorCount = 0;
    int          startCount = 0;
    int          clearCount = 0;
    int          respCount = 0;
    int          kickCnt = 0;
    int          kickSeen = 0;
    int          armCnt = -1;
    int          respDelay = 5;
    bit          respEnable = 1'b0;
    logic [31:0] respData = '0;
    logic [31:0] lastStartAddr = '0;
    logic [15:0] rd;

    ext_bus_bridge #(
        .DATA_WIDTH(16), .HOST_AW(25), .IDX_LSB(1), .SYNC_STAGES(SYNC),
        .SANITY_VAL(16'h50FE), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .data_o(data_o),
        .data_oe_o(data_oe_o), .addr_i(addr_i), .read_i(read_i), .write_i(write_i),
        .cs_i(cs_i), .cpu_rst_o(cpu_rst_o), .soc_rst_o(soc_rst_o),
        .bus_master_o(bus_master_o), .cpu_halt_o(cpu_halt_o),
        .tran_addr_o(tran_addr_o), .tran_data_o(tran_data_o), .tran_size_o(tran_size_o),
        .tran_we_o(tran_we_o), .tran_start_o(tran_start_o), .tran_clear_o(tran_clear_o),
        .tran_data_i(tran_data_i), .tran_ready_i(tran_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Pulse monitors: count start/clear cycles and remember the address issued with each start.
    always @(negedge clk_i) begin
        if (tran_start_o) begin
            startCount++;
            lastStartAddr = tran_addr_o;
        end
        if (tran_clear_o) clearCount++;
    end

    // SoC responder: auto-completes respDelay clocks after a start, or immediately on a manual kick.
    always @(negedge clk_i) begin
        tran_ready_i = 1'b0;
        if (kickSeen != kickCnt) begin
            kickSeen = kickCnt;
            tran_ready_i = 1'b1;
            tran_data_i = respData;
            respCount++;
        end else if (armCnt == 0) begin
            tran_ready_i = 1'b1;
            tran_data_i = respData;
            respCount++;
            armCnt = -1;
        end else if (armCnt > 0) begin
            armCnt--;
        end
        if (tran_start_o && respEnable) armCnt = respDelay - 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full host access: strobes and address held across the whole cs assertion.
    task automatic applyStimulus(input bit isWrite, input logic [3:0] idx, input logic [15:0] wdata);
        @(negedge clk_i);
        addr_i  = 25'h1F00001 | (25'(idx) << 1);
        data_i  = wdata;
        read_i  = isWrite;
        write_i = ~isWrite;
        cs_i    = 1'b1;
        repeat (SYNC + 2) @(negedge clk_i);
        cs_i = 1'b0;
        @(negedge clk_i);
        read_i  = 1'b1;
        write_i = 1'b1;
        repeat (SYNC + 1) @(negedge clk_i);
    endtask

    task automatic readReg(input logic [3:0] idx, output logic [15:0] val);
        applyStimulus(1'b0, idx, 16'h0000);
        val = data_o;
    endtask

    task automatic waitResp(input int expCount);
        int budget = 100;
        while (respCount < expCount && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        checkOutput("respDone", respCount, expCount);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        checkOutput("rstCpuRst", cpu_rst_o, 1);
        checkOutput("rstSocRst", soc_rst_o, 1);
        checkOutput("rstHalt", cpu_halt_o, 1);
        checkOutput("rstBusMaster", bus_master_o, 0);
        checkOutput("rstStart", tran_start_o, 0);
        checkOutput("rstDataO", data_o, 0);
        reset_i = 1'b1;

        readReg(4'd0, rd);  checkOutput("idReg", rd, 32'h50FE);
        readReg(4'd1, rd);  checkOutput("ctrlReset", rd, 32'h0103);
        readReg(4'd2, rd);  checkOutput("statusReset", rd, 32'h0);
        checkOutput("startIdle", startCount, 0);
        applyStimulus(1'b1, 4'd0, 16'hFFFF);
        readReg(4'd0, rd);  checkOutput("idReadOnly", rd, 32'h50FE);
        readReg(4'd6, rd);  checkOutput("unmapped6", rd, 32'h0);
        readReg(4'd3, rd);  checkOutput("unmapped3", rd, 32'h0);

        // Single word read transaction.
        applyStimulus(1'b1, 4'd4, 16'h1000);
        applyStimulus(1'b1, 4'd5, 16'h0000);
        applyStimulus(1'b1, 4'd8, 16'h5678);
        applyStimulus(1'b1, 4'd9, 16'h1234);
        respData = 32'hDEADBEEF; respDelay = 5; respEnable = 1'b1;
        applyStimulus(1'b1, 4'd1, 16'h0088);
        waitResp(1);
        checkOutput("startOnce", startCount, 1);
        checkOutput("tranAddr1", lastStartAddr, 32'h1000);
        checkOutput("tranSize1", tran_size_o, 2);
        checkOutput("tranWe1", tran_we_o, 0);
        checkOutput("tranData1", tran_data_o, 32'h12345678);
        checkOutput("cpuRstCleared", cpu_rst_o, 0);
        readReg(4'd12, rd); checkOutput("dataOut0", rd, 32'hBEEF);
        readReg(4'd13, rd); checkOutput("dataOut1", rd, 32'hDEAD);
        readReg(4'd2, rd);  checkOutput("statusDone", rd, 32'h2);
        readReg(4'd1, rd);  checkOutput("ctrlNoStart", rd, 32'h0080);

        // Auto-increment bursts and 32-bit wrap.
        respData = 32'hCAFE0001; respDelay = 2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd1, 16'h0248);
            waitResp(2 + i);
            checkOutput("burstAddr", lastStartAddr, 32'h1000 + 32'(2 * i));
        end
        readReg(4'd4, rd);  checkOutput("addrAfterBurst", rd, 32'h1006);
        applyStimulus(1'b1, 4'd4, 16'hFFFE);
        applyStimulus(1'b1, 4'd5, 16'hFFFF);
        applyStimulus(1'b1, 4'd1, 16'h0288);
        waitResp(5);
        checkOutput("wrapStartAddr", lastStartAddr, 32'hFFFFFFFE);
        readReg(4'd4, rd);  checkOutput("wrapLo", rd, 32'h0002);
        readReg(4'd5, rd);  checkOutput("wrapHi", rd, 32'h0000);
        checkOutput("startCount5", startCount, 5);

        // Start and address rewrite while busy.
        respEnable = 1'b0;
        applyStimulus(1'b1, 4'd4, 16'h2000);
        applyStimulus(1'b1, 4'd5, 16'h0000);
        applyStimulus(1'b1, 4'd1, 16'h0088);
        checkOutput("startCount6", startCount, 6);
        checkOutput("busyAddr", lastStartAddr, 32'h2000);
        applyStimulus(1'b1, 4'd1, 16'h0088);
        checkOutput("noRestart", startCount, 6);
        readReg(4'd2, rd);  checkOutput("statusBusy", rd, 32'h1);
        applyStimulus(1'b1, 4'd4, 16'h3000);
        checkOutput("tranAddrHeld", tran_addr_o, 32'h2000);
        respData = 32'h11112222;
        kickCnt++;
        repeat (3) @(negedge clk_i);
        checkOutput("kickResp", respCount, 6);
        readReg(4'd2, rd);  checkOutput("statusDone2", rd, 32'h2);
        readReg(4'd12, rd); checkOutput("dataOutKick0", rd, 32'h2222);
        readReg(4'd13, rd); checkOutput("dataOutKick1", rd, 32'h1111);
        applyStimulus(1'b1, 4'd1, 16'h0088);
        checkOutput("newAddrIssued", tran_addr_o, 32'h3000);
        applyStimulus(1'b1, 4'd1, 16'h0020);
        checkOutput("clearPulse", clearCount, 1);
        readReg(4'd2, rd);  checkOutput("statusCleared", rd, 32'h0);

        // Stuck transaction: watchdog only in the timeout build.
        applyStimulus(1'b1, 4'd1, 16'h0088);
        checkOutput("startCount8", startCount, 8);
        repeat (40) @(negedge clk_i);
`ifdef BRIDGE_TIMEOUT_EN
        readReg(4'd2, rd);  checkOutput("statusTimeout", rd, 32'h4);
        checkOutput("timeoutClear", clearCount, 2);
        applyStimulus(1'b1, 4'd1, 16'h0088);
        checkOutput("startAfterTimeout", startCount, 9);
        readReg(4'd2, rd);  checkOutput("statusBusyAgain", rd, 32'h1);
`else
        readReg(4'd2, rd);  checkOutput("statusStillBusy", rd, 32'h1);
        checkOutput("noTimeoutClear", clearCount, 1);
`endif

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        checkOutput("asyncDataO", data_o, 0);
        checkOutput("asyncCpuRst", cpu_rst_o, 1);
        checkOutput("asyncSocRst", soc_rst_o, 1);
        checkOutput("asyncHalt", cpu_halt_o, 1);
        checkOutput("asyncTranAddr", tran_addr_o, 0);
        checkOutput("asyncTranSize", tran_size_o, 0);
        checkOutput("asyncStart", tran_start_o, 0);
        checkOutput("asyncClear", tran_clear_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        readReg(4'd2, rd);  checkOutput("statusAfterRst", rd, 32'h0);
        readReg(4'd1, rd);  checkOutput("ctrlAfterRst", rd, 32'h0103);
        readReg(4'd4, rd);  checkOutput("addrAfterRst", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
